// File: rtl/reset_sequencer.sv
// Power-on / recovery reset sequencer: holds the DCM in reset, waits for lock with
// retry on timeout, then releases NUM_CHAN downstream reset domains in index order.
module reset_sequencer #(
  parameter int unsigned NUM_CHAN       = 4,
  parameter int unsigned DCM_RST_CYCLES = 4,
  parameter int unsigned LOCK_TIMEOUT   = 1024,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clkin,
  input  logic                resetin,
  input  logic                lock_in,
  input  logic                sw_rst_req,
  output logic                dcm_rst,
  output logic [NUM_CHAN-1:0] chan_rst_n,
  output logic                ready,
  output logic                timeout_err,
  output logic [3:0]          retry_cnt,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_DCM_RST   = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DCM_LAST  = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dcm_rst_q, dcm_rst_d;
  logic [NUM_CHAN-1:0]  chan_rst_n_q, chan_rst_n_d;
  logic                 ready_q, ready_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [3:0]           retry_cnt_q, retry_cnt_d;
  logic                 lock_meta_q, lock_meta_d;
  logic                 lock_s_q, lock_s_d;
  logic [NUM_CHAN-1:0]  rel_hit_c;

  // One release slot per channel; slots are distinct counter values, so at most one hits per cycle.
  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_rel
    assign rel_hit_c[g] = (cnt_q == CNT_W'(STAGE_GAP * (g + 1) - 1));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dcm_rst_d     = dcm_rst_q;
    chan_rst_n_d  = chan_rst_n_q;
    ready_d       = ready_q;
    timeout_err_d = 1'b0;
    retry_cnt_d   = retry_cnt_q;
    lock_meta_d   = lock_in;
    lock_s_d      = lock_meta_q;

    case (state_q)
      ST_DCM_RST: begin
        dcm_rst_d    = 1'b1;
        chan_rst_n_d = '0;
        ready_d      = 1'b0;
        if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == DCM_LAST) begin
          state_d   = ST_WAIT_LOCK;
          cnt_d     = '0;
          dcm_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sw_rst_req) begin
          state_d      = ST_DCM_RST;
          cnt_d        = '0;
          dcm_rst_d    = 1'b1;
          chan_rst_n_d = '0;
          ready_d      = 1'b0;
        end else if (lock_s_q) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == LOCK_LAST) begin
          timeout_err_d = 1'b1;
          if (retry_cnt_q != 4'hF) begin
            retry_cnt_d = retry_cnt_q + 4'd1;
          end
          state_d   = ST_DCM_RST;
          cnt_d     = '0;
          dcm_rst_d = 1'b1;
        end
      end

      ST_RELEASE: begin
        if (sw_rst_req || !lock_s_q) begin
          state_d      = ST_DCM_RST;
          cnt_d        = '0;
          dcm_rst_d    = 1'b1;
          chan_rst_n_d = '0;
          ready_d      = 1'b0;
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          chan_rst_n_d = chan_rst_n_q | rel_hit_c;
          if (rel_hit_c[NUM_CHAN-1]) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (sw_rst_req || !lock_s_q) begin
          state_d      = ST_DCM_RST;
          cnt_d        = '0;
          dcm_rst_d    = 1'b1;
          chan_rst_n_d = '0;
          ready_d      = 1'b0;
        end
      end

      default: begin
        state_d      = ST_DCM_RST;
        cnt_d        = '0;
        dcm_rst_d    = 1'b1;
        chan_rst_n_d = '0;
        ready_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkin or negedge resetin) begin
    if (!resetin) begin
      state_q       <= ST_DCM_RST;
      cnt_q         <= '0;
      dcm_rst_q     <= 1'b1;
      chan_rst_n_q  <= '0;
      ready_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      retry_cnt_q   <= 4'h0;
      lock_meta_q   <= 1'b0;
      lock_s_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dcm_rst_q     <= dcm_rst_d;
      chan_rst_n_q  <= chan_rst_n_d;
      ready_q       <= ready_d;
      timeout_err_q <= timeout_err_d;
      retry_cnt_q   <= retry_cnt_d;
      lock_meta_q   <= lock_meta_d;
      lock_s_q      <= lock_s_d;
    end
  end

  assign dcm_rst     = dcm_rst_q;
  assign chan_rst_n  = chan_rst_n_q;
  assign ready       = ready_q;
  assign timeout_err = timeout_err_q;
  assign retry_cnt   = retry_cnt_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output events (with their cycle)
// are queued by the stimulus; the monitor pops one whenever the outputs change.
module tb_reset_sequencer;

  localparam int NCH = 4;
  localparam int DRC = 4;
  localparam int LTO = 16;
  localparam int GAP = 8;
  localparam int CW  = 16;

  logic           clkin      = 1'b0;
  logic           resetin    = 1'b1;
  logic           lock_in    = 1'b1;
  logic           sw_rst_req = 1'b0;
  logic           dcm_rst;
  logic [NCH-1:0] chan_rst_n;
  logic           ready;
  logic           timeout_err;
  logic [3:0]     retry_cnt;
  logic [1:0]     state_dbg;

  reset_sequencer #(
    .NUM_CHAN      (NCH),
    .DCM_RST_CYCLES(DRC),
    .LOCK_TIMEOUT  (LTO),
    .STAGE_GAP     (GAP),
    .CNT_W         (CW)
  ) dut (
    .clkin      (clkin),
    .resetin    (resetin),
    .lock_in    (lock_in),
    .sw_rst_req (sw_rst_req),
    .dcm_rst    (dcm_rst),
    .chan_rst_n (chan_rst_n),
    .ready      (ready),
    .timeout_err(timeout_err),
    .retry_cnt  (retry_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       dcm;
    logic [3:0] chan;
    logic       rdy;
    logic       terr;
    logic [3:0] retry;
    logic [1:0] st;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  done   = 1'b0;

  function automatic void push_ev(int c, logic dcm, logic [3:0] chan, logic rdy,
                                  logic terr, logic [3:0] retry, logic [1:0] st);
    ev_t e;
    e.cyc = c; e.dcm = dcm; e.chan = chan; e.rdy = rdy;
    e.terr = terr; e.retry = retry; e.st = st;
    exp_q.push_back(e);
  endfunction

  // Normal progression from a DCM_RST entry at edge r with the counter at zero and lock held.
  function automatic void push_seq(int r, int nchan, logic [3:0] retry);
    push_ev(r + DRC, 1'b0, 4'h0, 1'b0, 1'b0, retry, 2'b01);
    for (int i = 0; i < nchan; i++) begin
      logic [3:0] m;
      m = 4'((1 << (i + 1)) - 1);
      push_ev(r + DRC + 1 + GAP * (i + 1), 1'b0, m, (i == NCH - 1), 1'b0, retry,
              (i == NCH - 1) ? 2'b11 : 2'b10);
    end
  endfunction

  function automatic logic [3:0] sat(int v);
    return (v > 15) ? 4'hF : 4'(v);
  endfunction

  task automatic wait_cyc(int t);
    do begin
      @(posedge clkin);
      #2;
    end while (cyc < t);
  endtask

  // Monitor: an event is any change of dcm_rst/chan_rst_n/ready/retry_cnt, or a timeout pulse.
  initial begin
    logic [9:0] prev;
    logic [9:0] cur;
    ev_t        e;
    prev = 'x;
    while (!done) begin
      @(negedge clkin or negedge resetin);
      #1;
      cur = {dcm_rst, chan_rst_n, ready, retry_cnt};
      if (cur !== prev || timeout_err === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got dcm=%b chan=%b rdy=%b terr=%b retry=%0d st=%b",
                   cyc, dcm_rst, chan_rst_n, ready, timeout_err, retry_cnt, state_dbg);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.dcm !== dcm_rst || e.chan !== chan_rst_n || e.rdy !== ready ||
              e.terr !== timeout_err || e.retry !== retry_cnt || e.st !== state_dbg) begin
            errors++;
            $display("FAIL event got cyc=%0d dcm=%b chan=%b rdy=%b terr=%b retry=%0d st=%b required cyc=%0d dcm=%b chan=%b rdy=%b terr=%b retry=%0d st=%b",
                     cyc, dcm_rst, chan_rst_n, ready, timeout_err, retry_cnt, state_dbg,
                     e.cyc, e.dcm, e.chan, e.rdy, e.terr, e.retry, e.st);
          end
        end
      end
      prev = cur;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus
  initial begin
    int r;
    int c;
    int b;

    // Cold start with lock present throughout
    push_ev(0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'b00);
    #1 resetin = 1'b0;
    wait_cyc(3);
    resetin = 1'b1;
    r = cyc;
    push_seq(r, NCH, 4'h0);

    // One-cycle lock drop in RUN, then a software request while chan_rst_n=0011
    wait_cyc(r + 40);
    c = cyc;
    lock_in = 1'b0;
    r = c + 3;
    push_ev(r, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'b00);
    push_seq(r, 2, 4'h0);
    push_ev(r + 23, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'b00);
    push_seq(r + 23, NCH, 4'h0);
    wait_cyc(c + 1);
    lock_in = 1'b1;
    wait_cyc(r + 22);
    sw_rst_req = 1'b1;
    wait_cyc(r + 23);
    sw_rst_req = 1'b0;
    r = r + 23;

    // Asynchronous reset between edges while in RUN
    wait_cyc(r + 40);
    push_ev(cyc, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 2'b00);
    resetin = 1'b0;
    lock_in = 1'b0;

    // Lock absent for 40 cycles after release: two timeouts, then normal release
    wait_cyc(cyc + 3);
    resetin = 1'b1;
    b = cyc;
    push_ev(b + 4,  1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 2'b01);
    push_ev(b + 20, 1'b1, 4'h0, 1'b0, 1'b1, 4'h1, 2'b00);
    push_ev(b + 24, 1'b0, 4'h0, 1'b0, 1'b0, 4'h1, 2'b01);
    push_ev(b + 40, 1'b1, 4'h0, 1'b0, 1'b1, 4'h2, 2'b00);
    push_seq(b + 40, NCH, 4'h2);
    wait_cyc(b + 40);
    lock_in = 1'b1;

    // Permanent lock loss from RUN: retry_cnt saturates at 15, pulses continue
    wait_cyc(b + 80);
    c = cyc;
    lock_in = 1'b0;
    r = c + 3;
    push_ev(r, 1'b1, 4'h0, 1'b0, 1'b0, 4'h2, 2'b00);
    for (int k = 0; k < 16; k++) begin
      push_ev(r + 20 * k + 4,  1'b0, 4'h0, 1'b0, 1'b0, sat(2 + k), 2'b01);
      push_ev(r + 20 * (k + 1), 1'b1, 4'h0, 1'b0, 1'b1, sat(3 + k), 2'b00);
    end
    push_ev(r + 324, 1'b0, 4'h0, 1'b0, 1'b0, 4'hF, 2'b01);
    wait_cyc(r + 330);
    done = 1'b1;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
